// File: rtl/tc_timer_if.sv
// CPU data-memory bus as seen by a memory-mapped peripheral: the CPU masters
// address, byte enables and store data; the peripheral returns read data.
interface tc_timer_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output byteen,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  byteen,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes and a
// level interrupt; CTRL/PRESET/COUNT live in a 16-byte window at BASE.
module tc_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic      clk,
    input  logic      reset,
    tc_timer_if.slave bus,
    output logic      irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic [31:0] count_nxt_s;
    logic        irq_flag_r;

    logic        sel_s;
    logic        wr_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic [3:0]  ctrl_wdata_s;
    logic        en_eff_s;
    logic        auto_s;
    logic        flag_set_s;
    logic        flag_clr_fsm_s;
    logic        en_clr_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^bus.addr[1:0];
    assign auto_s        = (ctrl_r[2:1] == 2'd1);
    assign irq           = irq_flag_r & ctrl_r[3];

    // Address decode and the CTRL value a write in this cycle would produce.
    always_comb begin
        sel_s       = (bus.addr[31:4] == BASE[31:4]);
        wr_s        = sel_s && (bus.byteen != 4'd0);
        wr_ctrl_s   = wr_s && (bus.addr[3:2] == 2'd0);
        wr_preset_s = wr_s && (bus.addr[3:2] == 2'd1);
        if (bus.byteen[0]) begin
            ctrl_wdata_s = bus.wdata[3:0];
        end else begin
            ctrl_wdata_s = ctrl_r;
        end
        // IDLE looks at the enable being written so LOAD follows the enabling store directly.
        if (wr_ctrl_s) begin
            en_eff_s = ctrl_wdata_s[0];
        end else begin
            en_eff_s = ctrl_r[0];
        end
    end

    // Counter FSM: next state, next COUNT and flag/enable side effects.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        flag_set_s     = 1'b0;
        flag_clr_fsm_s = 1'b0;
        en_clr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (en_eff_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                count_nxt_s    = preset_r;
                flag_clr_fsm_s = 1'b1;
                state_nxt_s    = CNT;
            end
            CNT: begin
                if (!ctrl_r[0]) begin
                    state_nxt_s = IDLE;
                end else if (count_r > 32'd1) begin
                    count_nxt_s = count_r - 32'd1;
                end else begin
                    count_nxt_s = 32'd0;
                    flag_set_s  = 1'b1;
                    en_clr_s    = !auto_s;
                    state_nxt_s = INT;
                end
            end
            INT: begin
                if (auto_s) begin
                    flag_clr_fsm_s = 1'b1;
                    state_nxt_s    = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Read mux; anything outside the window or in the reserved slot reads zero.
    always_comb begin
        bus.rdata = 32'd0;
        if (sel_s) begin
            case (bus.addr[3:2])
                2'd0:    bus.rdata = {28'd0, ctrl_r};
                2'd1:    bus.rdata = preset_r;
                2'd2:    bus.rdata = count_r;
                default: bus.rdata = 32'd0;
            endcase
        end else begin
            bus.rdata = 32'd0;
        end
    end

    // Register state; a CPU CTRL write beats the FSM's enable clear, a flag set beats any clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ctrl_r     <= 4'd0;
            preset_r   <= 32'd0;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            if (wr_ctrl_s) begin
                ctrl_r <= ctrl_wdata_s;
            end else if (en_clr_s) begin
                ctrl_r[0] <= 1'b0;
            end
            if (wr_preset_s) begin
                preset_r <= merge_bytes(preset_r, bus.wdata, bus.byteen);
            end
            if (flag_set_s) begin
                irq_flag_r <= 1'b1;
            end else if (wr_ctrl_s || flag_clr_fsm_s) begin
                irq_flag_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: a cycle-timeline model checked against rdata
// and irq every cycle, plus literal expectations at key points.
module tb_tc_timer;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    tc_timer_if bus ();

    tc_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    // Model state: visible registers plus a timeline of the current run.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    bit          m_run;
    longint      cyc    = 0;
    longint      m_load = 0;
    longint      m_n    = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Timeline model: a run loads at edge m_load, then counts down from
    // max(PRESET,1) one step per edge, hits the terminal edge m_n edges after
    // the load, and spends one more edge in the interrupt step.
    always @(posedge clk) begin : model
        logic [31:0] a;
        bit          sel, wr_c, wr_p, en_now, en_clr, clr, set_f, auto_m;
        longint      d;
        cyc++;
        a      = bus.addr;
        sel    = (a[31:4] == BASE[31:4]);
        wr_c   = sel && (bus.byteen != 4'd0) && (a[3:2] == 2'd0);
        wr_p   = sel && (bus.byteen != 4'd0) && (a[3:2] == 2'd1);
        en_clr = 1'b0;
        clr    = 1'b0;
        set_f  = 1'b0;
        if (reset) begin
            m_ctrl   = 4'd0;
            m_preset = 32'd0;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_run    = 1'b0;
        end else begin
            auto_m = (m_ctrl[2:1] == 2'd1);
            en_now = (wr_c && bus.byteen[0]) ? bus.wdata[0] : m_ctrl[0];
            if (!m_run) begin
                if (en_now) begin
                    m_run  = 1'b1;
                    m_load = cyc + 1;
                end
            end else if (cyc == m_load) begin
                m_count = m_preset;
                m_n     = (m_preset == 32'd0) ? 1 : longint'(m_preset);
                clr     = 1'b1;
            end else begin
                d = cyc - m_load;
                if (d <= m_n) begin
                    if (!m_ctrl[0]) begin
                        m_run = 1'b0;
                    end else if (d < m_n) begin
                        m_count = 32'(m_n - d);
                    end else begin
                        m_count = 32'd0;
                        set_f   = 1'b1;
                        en_clr  = !auto_m;
                    end
                end else if (auto_m) begin
                    clr    = 1'b1;
                    m_load = cyc + 1;
                end else begin
                    m_run = 1'b0;
                end
            end
            if (wr_c) begin
                if (bus.byteen[0]) m_ctrl = bus.wdata[3:0];
            end else if (en_clr) begin
                m_ctrl[0] = 1'b0;
            end
            if (wr_p) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.byteen[i]) m_preset[8*i +: 8] = bus.wdata[8*i +: 8];
                end
            end
            if (set_f) m_flag = 1'b1;
            else if (wr_c || clr) m_flag = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_rdata", bus.rdata, exp_rd(bus.addr));
            chk("cyc_irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr   = a;
        bus.wdata  = d;
        bus.byteen = be;
        tick(1);
        bus.byteen = 4'd0;
        bus.wdata  = 32'd0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    task automatic expect_irq(input string name, input logic exp);
        chk(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.addr   = 32'd0;
        bus.byteen = 4'd0;
        bus.wdata  = 32'd0;
        tick(2);
        reset = 1'b0;
        armed = 1'b1;

        expect_rd("rst_ctrl", A_CTRL, 32'd0);
        expect_rd("rst_preset", A_PRESET, 32'd0);
        expect_rd("rst_count", A_COUNT, 32'd0);
        expect_rd("rst_rsvd", A_RSVD, 32'd0);
        expect_rd("out_of_window", 32'h0000_7F10, 32'd0);
        expect_irq("rst_irq", 1'b0);

        // One-shot, PRESET=5, IM set.
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick(1);
        expect_rd("os_load", A_COUNT, 32'd5);
        tick(3);
        expect_rd("os_cnt2", A_COUNT, 32'd2);
        tick(1);
        expect_rd("os_cnt1", A_COUNT, 32'd1);
        expect_irq("os_irq_pre", 1'b0);
        tick(1);
        expect_rd("os_cnt0", A_COUNT, 32'd0);
        expect_irq("os_irq_rise", 1'b1);
        expect_rd("os_ctrl_en_clr", A_CTRL, 32'd8);
        tick(3);
        expect_irq("os_irq_hold", 1'b1);
        wr(A_CTRL, 32'd0, 4'hF);
        expect_irq("os_irq_clr", 1'b0);

        // Auto-reload, PRESET=3: period 5.
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        tick(1);
        expect_rd("ar_load", A_COUNT, 32'd3);
        tick(2);
        expect_rd("ar_cnt1", A_COUNT, 32'd1);
        expect_irq("ar_pre", 1'b0);
        tick(1);
        expect_irq("ar_pulse0", 1'b1);
        for (int p = 0; p < 2; p++) begin
            tick(1);
            expect_irq("ar_low", 1'b0);
            tick(4);
            expect_irq("ar_pulse", 1'b1);
        end
        wr(A_CTRL, 32'd0, 4'hF);
        tick(3);

        // PRESET=0 behaves like 1.
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        tick(1);
        expect_irq("p0_load", 1'b0);
        tick(1);
        expect_irq("p0_int", 1'b1);
        wr(A_CTRL, 32'd0, 4'hF);
        tick(3);

        // CTRL write on the terminal edge: written En kept, flag still set.
        do_reset();
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick(3);
        wr(A_CTRL, 32'h9, 4'hF);
        expect_irq("sim_flag_set", 1'b1);
        expect_rd("sim_ctrl_wins", A_CTRL, 32'h9);
        tick(4);
        expect_irq("sim_reload_clr", 1'b0);
        wr(A_CTRL, 32'd0, 4'hF);
        tick(3);

        // Byte-lane merge and ignored writes.
        do_reset();
        wr(A_PRESET, 32'h1122_3344, 4'hF);
        wr(A_PRESET, 32'hAABB_CCDD, 4'b0101);
        expect_rd("be_merge", A_PRESET, 32'h11BB_33DD);
        wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        expect_rd("count_ro", A_COUNT, 32'd0);
        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        expect_rd("rsvd_ro", A_RSVD, 32'd0);
        wr(32'h0000_7F14, 32'h0, 4'hF);
        expect_rd("outside_wr", A_PRESET, 32'h11BB_33DD);
        wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        expect_rd("ctrl_hi_bits", A_CTRL, 32'd0);

        // One-shot with IM=0; enabling IM later via CTRL write clears the flag.
        do_reset();
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        tick(5);
        expect_irq("im0_masked", 1'b0);
        wr(A_CTRL, 32'h8, 4'hF);
        expect_irq("im1_flag_clr", 1'b0);
        expect_rd("im1_ctrl", A_CTRL, 32'h8);

        // Mid-count disable, re-enable, reset.
        do_reset();
        wr(A_PRESET, 32'd10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        tick(3);
        wr(A_CTRL, 32'h0, 4'hF);
        tick(3);
        expect_rd("freeze7", A_COUNT, 32'd7);
        wr(A_CTRL, 32'h1, 4'hF);
        tick(1);
        expect_rd("reload10", A_COUNT, 32'd10);
        tick(2);
        expect_rd("recount8", A_COUNT, 32'd8);
        do_reset();
        expect_rd("mid_rst_ctrl", A_CTRL, 32'd0);
        expect_rd("mid_rst_preset", A_PRESET, 32'd0);
        expect_rd("mid_rst_count", A_COUNT, 32'd0);
        expect_irq("mid_rst_irq", 1'b0);
        tick(4);
        expect_rd("post_rst_count", A_COUNT, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
